// File: rtl/ycbcr_pack.sv
// ycbcr_pack: gathers camera YCbCr 4:2:2 bytes (Y0, Cb, Y1, Cr) into 32-bit
// pixel-pair words, tags each with frame/line sideband bits and hands them
// downstream through a small first-word-fall-through buffer.
module ycbcr_pack #(
    parameter int LINE_WORDS = 320,
    parameter int FRM_LINES  = 400,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        vsync_i,
    input  logic        href_i,
    input  logic        pix_vld_i,
    input  logic [7:0]  pix_i,
    output logic        vld_o,
    input  logic        ds_rdy,
    output logic [35:0] dout,
    output logic        ovf_o,
    output logic        err_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [8:0]    LAST_WORD = 9'(LINE_WORDS - 1);
    localparam logic [8:0]    LAST_LINE = 9'(FRM_LINES - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        ACTIVE   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Input conditioning
    logic en_s1;
    logic en_s2;
    logic vsync_q;
    logic href_q;

    logic vsync_fall;
    logic vsync_rise;
    logic href_fall;

    // Packing counters
    logic [1:0] lane_cnt;
    logic [8:0] word_cnt;
    logic [8:0] line_cnt;

    // Qualified events in ACTIVE
    logic in_active;
    logic sof_evt;
    logic abort;
    logic short_line;
    logic capture;
    logic word_done;
    logic last_word;
    logic last_line;
    logic frame_done;

    // Capture stage: first three bytes of the word in flight
    logic [7:0] byte0_p0;
    logic [7:0] byte1_p0;
    logic [7:0] byte2_p0;

    // Push stage: completed word waiting to enter the buffer
    logic [35:0] word_p1;
    logic        vld_p1;

    // Output buffer
    logic [35:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          drop;

    assign vsync_fall = vsync_q & ~vsync_i;
    assign vsync_rise = ~vsync_q & vsync_i;
    assign href_fall  = href_q & ~href_i;

    assign in_active  = (state == ACTIVE);
    assign sof_evt    = (state == WAIT_SOF) & vsync_fall;
    // A new vsync while the frame is still open overrides everything else.
    assign abort      = in_active & vsync_rise;
    // href can only fall when it is low, so this never coincides with a capture.
    assign short_line = in_active & ~abort & href_fall &
                        ((lane_cnt != 2'd0) | (word_cnt != 9'd0));
    assign capture    = in_active & ~abort & pix_vld_i & href_i;
    assign word_done  = capture & (lane_cnt == 2'd3);
    assign last_word  = (word_cnt == LAST_WORD);
    assign last_line  = (line_cnt == LAST_LINE);
    assign frame_done = word_done & last_word & last_line;

    // Enable synchronizer and edge-detect history for the camera strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_s1   <= 1'b0;
            en_s2   <= 1'b0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
        end else begin
            en_s1   <= en;
            en_s2   <= en_s1;
            vsync_q <= vsync_i;
            href_q  <= href_i;
        end
    end

    // Frame state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame sequencing: enable is only looked at from IDLE, so a mid-frame
    // drop of en lets the current frame finish
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en_s2) begin
                    state_nxt = WAIT_SOF;
                end
            end
            WAIT_SOF: begin
                if (vsync_fall) begin
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (abort) begin
                    state_nxt = WAIT_SOF;
                end else if (frame_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Byte lane, word and line position within the frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_cnt <= 2'd0;
            word_cnt <= 9'd0;
            line_cnt <= 9'd0;
        end else if (sof_evt) begin
            lane_cnt <= 2'd0;
            word_cnt <= 9'd0;
            line_cnt <= 9'd0;
        end else if (abort || short_line) begin
            // Partial word is abandoned; word/line position is kept.
            lane_cnt <= 2'd0;
        end else if (capture) begin
            lane_cnt <= lane_cnt + 2'd1;
            if (word_done) begin
                if (last_word) begin
                    word_cnt <= 9'd0;
                    line_cnt <= line_cnt + 9'd1;
                end else begin
                    word_cnt <= word_cnt + 9'd1;
                end
            end
        end
    end

    // ---- capture stage (p0): hold lanes 0..2 until the Cr byte arrives ----
    always_ff @(posedge clk) begin
        if (capture) begin
            case (lane_cnt)
                2'd0:    byte0_p0 <= pix_i;
                2'd1:    byte1_p0 <= pix_i;
                2'd2:    byte2_p0 <= pix_i;
                default: ;
            endcase
        end
    end

    // ---- push stage (p1): completed word with sideband {0, eol, eof, sof} ----
    always_ff @(posedge clk) begin
        if (word_done) begin
            word_p1 <= {1'b0,
                        last_word,
                        last_word & last_line,
                        (word_cnt == 9'd0) & (line_cnt == 9'd0),
                        pix_i, byte2_p0, byte1_p0, byte0_p0};
        end
    end

    // Push-stage valid; cleared by reset so a half-built frame never reaches the buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= word_done;
        end
    end

    // ---- buffer stage: FWFT FIFO, a pop frees the slot for a simultaneous push ----
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop     = ~empty & ds_rdy;
    assign push_ok = vld_p1 & (~full | pop);
    assign drop    = vld_p1 & full & ~pop;

    // Buffer storage write
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= word_p1;
        end
    end

    // Buffer pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_o <= 1'b0;
            err_o <= 1'b0;
        end else begin
            ovf_o <= ovf_o | drop;
            err_o <= err_o | abort | short_line;
        end
    end

    assign vld_o = ~empty;
    assign dout  = empty ? 36'h0 : mem[rd_ptr];

endmodule

// File: tb/tb_ycbcr_pack.sv
// tb_ycbcr_pack: directed scenarios plus randomized frames, with a
// word-level behavioural model of the packer compared every cycle.
`timescale 1ns/1ps
module tb_ycbcr_pack;

    localparam int LW = 4;
    localparam int FL = 2;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        vsync_i;
    logic        href_i;
    logic        pix_vld_i;
    logic [7:0]  pix_i;
    logic        vld_o;
    logic        ds_rdy;
    logic [35:0] dout;
    logic        ovf_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;
    bit rand_rdy = 1'b0;

    ycbcr_pack #(.LINE_WORDS(LW), .FRM_LINES(FL), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .en(en), .vsync_i(vsync_i), .href_i(href_i),
        .pix_vld_i(pix_vld_i), .pix_i(pix_i), .vld_o(vld_o), .ds_rdy(ds_rdy),
        .dout(dout), .ovf_o(ovf_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int          m_state;        // 0 idle, 1 waiting for start of frame, 2 active
    bit          m_en1, m_en2, m_vs, m_hr;
    int          m_lane, m_word, m_line;
    logic [7:0]  m_b [4];
    bit          m_pend;
    logic [35:0] m_pend_w;
    logic [35:0] m_q [$];        // buffered words, head first
    logic [35:0] m_log [$];      // every word handed downstream
    bit          m_ovf, m_err;

    int          exp_sb  [8] = '{1, 0, 0, 4, 0, 0, 0, 6};
    logic [35:0] exp_ovf [4] = '{36'h1_03020100, 36'h0_13121110, 36'h0_23222120, 36'h4_33323130};

    task automatic model_reset();
        m_state = 0;
        m_en1 = 0; m_en2 = 0; m_vs = 0; m_hr = 0;
        m_lane = 0; m_word = 0; m_line = 0;
        m_pend = 0;
        m_q.delete();
        m_ovf = 0; m_err = 0;
    endtask

    task automatic model_step();
        bit sofw, eolw, eofw;
        if (m_q.size() != 0 && ds_rdy) begin
            m_log.push_back(m_q[0]);
            void'(m_q.pop_front());
        end
        if (m_pend) begin
            if (m_q.size() < FD) m_q.push_back(m_pend_w);
            else m_ovf = 1;
        end
        m_pend = 0;
        if (m_state == 0) begin
            if (m_en2) m_state = 1;
        end else if (m_state == 1) begin
            if (m_vs && !vsync_i) begin
                m_state = 2; m_lane = 0; m_word = 0; m_line = 0;
            end
        end else begin
            if (!m_vs && vsync_i) begin
                m_err = 1; m_lane = 0; m_state = 1;
            end else if (m_hr && !href_i && (m_lane != 0 || m_word != 0)) begin
                m_err = 1; m_lane = 0;
            end else if (href_i && pix_vld_i) begin
                m_b[m_lane] = pix_i;
                if (m_lane == 3) begin
                    sofw = (m_word == 0) && (m_line == 0);
                    eolw = (m_word == LW - 1);
                    eofw = eolw && (m_line == FL - 1);
                    m_pend = 1;
                    m_pend_w = {1'b0, eolw, eofw, sofw, m_b[3], m_b[2], m_b[1], m_b[0]};
                    if (eolw) begin m_word = 0; m_line++; end
                    else m_word++;
                    if (eofw) m_state = 0;
                    m_lane = 0;
                end else begin
                    m_lane++;
                end
            end
        end
        m_en2 = m_en1; m_en1 = en; m_vs = vsync_i; m_hr = href_i;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("vld_o", {35'b0, vld_o}, 36'(m_q.size() != 0));
        if (m_q.size() != 0) chk("dout", dout, m_q[0]);
        chk("ovf_o", {35'b0, ovf_o}, {35'b0, m_ovf});
        chk("err_o", {35'b0, err_o}, {35'b0, m_err});
    endtask

    // One clock: drive at the falling edge, model the rising edge, compare at the next falling edge.
    task automatic cyc(input logic hr, input logic pv, input logic [7:0] p);
        href_i = hr; pix_vld_i = pv; pix_i = p;
        if (rand_rdy) ds_rdy = ($urandom_range(0, 3) != 0);
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic idle(input int n, input logic hr);
        for (int i = 0; i < n; i++) cyc(hr, 1'b0, 8'h00);
    endtask

    task automatic send_word(input logic [7:0] base);
        for (int j = 0; j < 4; j++) cyc(1'b1, 1'b1, base + 8'(j));
    endtask

    task automatic start_frame();
        vsync_i = 1'b1;
        idle(6, 1'b0);
        vsync_i = 1'b0;
        idle(1, 1'b0);
    endtask

    // Reset asserted between clock edges so the asynchronous clear is visible at once.
    task automatic pulse_reset();
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_vld", {35'b0, vld_o}, 36'h0);
        chk("rst_dout", dout, 36'h0);
        chk("rst_ovf", {35'b0, ovf_o}, 36'h0);
        chk("rst_err", {35'b0, err_o}, 36'h0);
        @(negedge clk);
        compare_model();
        rst = 1'b0;
    endtask

    int   mark;
    int   nb, sent, abl, ngap;
    logic pv;

    initial begin
        rst = 1'b1; en = 1'b0; vsync_i = 1'b0; href_i = 1'b0;
        pix_vld_i = 1'b0; pix_i = 8'h00; ds_rdy = 1'b1;
        model_reset();
        #1;
        chk("init_vld", {35'b0, vld_o}, 36'h0);
        chk("init_dout", dout, 36'h0);
        chk("init_flags", {34'b0, ovf_o, err_o}, 36'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // First word latency and content, then a complete frame
        en = 1'b1;
        mark = m_log.size();
        start_frame();
        cyc(1'b1, 1'b1, 8'h10);
        cyc(1'b1, 1'b1, 8'h80);
        cyc(1'b1, 1'b1, 8'h20);
        cyc(1'b1, 1'b1, 8'h90);
        chk("latency_early_vld", {35'b0, vld_o}, 36'h0);
        cyc(1'b1, 1'b0, 8'h00);
        chk("latency_vld", {35'b0, vld_o}, 36'h1);
        chk("first_word", dout, 36'h1_9020_8010);
        send_word(8'h30); send_word(8'h40); send_word(8'h50);
        idle(3, 1'b0);
        chk("eol_no_err", {35'b0, err_o}, 36'h0);
        en = 1'b0;
        send_word(8'h60); send_word(8'h64); send_word(8'h68); send_word(8'h6C);
        idle(4, 1'b0);
        chk("frame_words", 36'(m_log.size() - mark), 36'd8);
        if (m_log.size() >= mark + 8)
            for (int i = 0; i < 8; i++)
                chk("frame_sb", {32'b0, m_log[mark + i][35:32]}, 36'(exp_sb[i]));
        start_frame();
        send_word(8'h70);
        idle(3, 1'b0);
        chk("idle_after_frame_vld", {35'b0, vld_o}, 36'h0);
        chk("idle_after_frame_words", 36'(m_log.size() - mark), 36'd8);

        // Overflow with a stalled consumer
        en = 1'b1;
        pulse_reset();
        ds_rdy = 1'b0;
        mark = m_log.size();
        start_frame();
        for (int k = 0; k < 4; k++) send_word(8'(16 * k));
        idle(2, 1'b0);
        send_word(8'h40); send_word(8'h50);
        idle(3, 1'b1);
        chk("ovf_set", {35'b0, ovf_o}, 36'h1);
        chk("ovf_head_kept", dout, 36'h1_03020100);
        ds_rdy = 1'b1;
        idle(6, 1'b1);
        chk("ovf_words", 36'(m_log.size() - mark), 36'd4);
        if (m_log.size() >= mark + 4)
            for (int i = 0; i < 4; i++) chk("ovf_order", m_log[mark + i], exp_ovf[i]);

        // Short line
        pulse_reset();
        mark = m_log.size();
        start_frame();
        cyc(1'b1, 1'b1, 8'hC0);
        cyc(1'b1, 1'b1, 8'hC1);
        idle(2, 1'b0);
        chk("short_line_err", {35'b0, err_o}, 36'h1);
        send_word(8'hD0);
        idle(3, 1'b0);
        chk("short_line_words", 36'(m_log.size() - mark), 36'd1);
        if (m_log.size() > mark) chk("short_line_relane", m_log[mark], 36'h1_D3D2D1D0);

        // vsync rising mid-frame at line 1, enable dropped at the same time
        pulse_reset();
        mark = m_log.size();
        start_frame();
        send_word(8'h40); send_word(8'h50); send_word(8'h60); send_word(8'h70);
        idle(2, 1'b0);
        send_word(8'h80);
        cyc(1'b1, 1'b1, 8'h90);
        cyc(1'b1, 1'b1, 8'h91);
        vsync_i = 1'b1; en = 1'b0;
        cyc(1'b1, 1'b0, 8'h00);
        idle(4, 1'b0);
        chk("vsync_abort_err", {35'b0, err_o}, 36'h1);
        chk("vsync_abort_words", 36'(m_log.size() - mark), 36'd5);
        vsync_i = 1'b0;
        idle(1, 1'b0);
        send_word(8'hE0);
        idle(3, 1'b0);
        chk("refresh_words", 36'(m_log.size() - mark), 36'd6);
        if (m_log.size() >= mark + 6) chk("refresh_sof", m_log[mark + 5], 36'h1_E3E2E1E0);
        en = 1'b1;

        // Reset with words buffered
        pulse_reset();
        ds_rdy = 1'b0;
        start_frame();
        send_word(8'hA0); send_word(8'hB0); send_word(8'hC0);
        idle(2, 1'b1);
        chk("buffered_before_rst", {35'b0, vld_o}, 36'h1);
        pulse_reset();
        mark = m_log.size();
        ds_rdy = 1'b1;
        send_word(8'h55);
        idle(3, 1'b0);
        chk("no_word_before_sof", 36'(m_log.size() - mark), 36'd0);
        start_frame();
        send_word(8'h60);
        idle(3, 1'b0);
        chk("post_rst_words", 36'(m_log.size() - mark), 36'd1);
        if (m_log.size() > mark) chk("post_rst_sof", m_log[mark], 36'h1_63626160);

        // Randomized frames with random back-pressure, glitches and aborts
        pulse_reset();
        rand_rdy = 1'b1;
        for (int f = 0; f < 12; f++) begin
            en = ($urandom_range(0, 5) != 0);
            vsync_i = 1'b1;
            ngap = $urandom_range(3, 7);
            for (int g = 0; g < ngap; g++) cyc(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            vsync_i = 1'b0;
            idle(1, 1'b0);
            abl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, FL - 1) : -1;
            for (int l = 0; l < FL; l++) begin
                nb = 4 * LW;
                if (l == abl || $urandom_range(0, 5) == 0) nb = $urandom_range(1, 4 * LW - 1);
                sent = 0;
                while (sent < nb) begin
                    pv = ($urandom_range(0, 3) != 0);
                    cyc(1'b1, pv, 8'($urandom));
                    if (pv) sent++;
                end
                if (l == abl) begin
                    vsync_i = 1'b1;
                    cyc(1'b1, 1'b0, 8'h00);
                    break;
                end
                ngap = $urandom_range(1, 3);
                for (int g = 0; g < ngap; g++) cyc(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            end
        end
        rand_rdy = 1'b0;
        ds_rdy = 1'b1;
        idle(10, 1'b0);
        chk("drained", {35'b0, vld_o}, 36'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ycbcr_pack.md
YCBCR_PACK -- requirements
Module: ycbcr_pack

Interface
REQ-001 Parameter LINE_WORDS, default 320: number of 32-bit pixel-pair words per active line, equal to 1280 bytes.
REQ-002 Parameter FRM_LINES, default 400: number of active lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 4: output buffer depth in words; must be a power of 2.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port en, input, 1 bit: packer enable; applied only at frame boundaries.
REQ-007 Port vsync_i, input, 1 bit: camera vertical sync, high during frame blanking.
REQ-008 Port href_i, input, 1 bit: camera line-active qualifier.
REQ-009 Port pix_vld_i, input, 1 bit: byte strobe; `pix_i` is valid when `pix_vld_i` and `href_i` are both high.
REQ-010 Port pix_i, input, 8 bits: camera byte, arriving in the repeating order Y0, Cb, Y1, Cr.
REQ-011 Port vld_o, output, 1 bit: `dout` valid.
REQ-012 Port ds_rdy, input, 1 bit: downstream ready; a word transfers on `vld_o && ds_rdy`.
REQ-013 Port dout, output, 36 bits: {sb[3:0], cr, y1, cb, y0}.
REQ-014 Port ovf_o, output, 1 bit: sticky flag, set when a word is dropped because the buffer is full.
REQ-015 Port err_o, output, 1 bit: sticky flag, set on a framing error.

Function
REQ-016 The state machine SHALL have three states: IDLE, WAIT_SOF and ACTIVE.
REQ-017 IDLE SHALL go to WAIT_SOF when `en` (registered through a 2-flop synchronizer) is high.
REQ-018 WAIT_SOF SHALL go to ACTIVE on the falling edge of `vsync_i`, detected with a registered `vsync_i` compared against the current value.
REQ-019 ACTIVE SHALL go to IDLE after the final word of the frame: line FRM_LINES-1, word LINE_WORDS-1.
REQ-020 A rising edge of `vsync_i` in ACTIVE before the frame completes SHALL set `err_o`, discard any partial word, and go to WAIT_SOF.
REQ-021 Qualified bytes SHALL be captured only in ACTIVE; bytes in IDLE and WAIT_SOF SHALL be ignored.
REQ-022 A 2-bit byte-lane counter SHALL place bytes into lanes [7:0], [15:8], [23:16], [31:24] in that order, wrapping 3 to 0.
REQ-023 When lane 3 is written, the completed word SHALL be pushed to the buffer in the same cycle.
REQ-024 A 9-bit word counter SHALL count 0..LINE_WORDS-1 and wrap to 0, incrementing a 9-bit line counter.
REQ-025 The line counter SHALL clear on the transition into ACTIVE.
REQ-026 Sideband sb[0] SHALL be set on word 0 of line 0 (start of frame).
REQ-027 Sideband sb[1] SHALL be set on the last word of the frame (end of frame).
REQ-028 Sideband sb[2] SHALL be set on the last word of every line (end of line).
REQ-029 Sideband sb[3] SHALL be 0.
REQ-030 When `href_i` falls with the lane counter non-zero or the word counter non-zero (short line), the block SHALL set `err_o`, reset the lane counter, and keep the word and line counters unchanged.
REQ-031 The buffer SHALL be first-word-fall-through, FIFO_DEPTH words by 36 bits.
REQ-032 `vld_o` SHALL equal buffer not-empty.
REQ-033 `dout` SHALL be the buffer head.
REQ-034 Latency SHALL be 1 clock: a word whose byte 3 is captured at edge N SHALL be visible on `dout` with `vld_o` high after edge N+1, when the buffer was empty.
REQ-035 A push to a full buffer SHALL drop the incoming word, set `ovf_o`, and leave buffer contents intact.
REQ-036 A push to a full buffer in the same cycle as a pop SHALL be accepted, with no overflow.
REQ-037 A push to an empty buffer with `ds_rdy` high SHALL NOT bypass the buffer; the 1-clock latency SHALL still apply.
REQ-038 `dout` SHALL hold its value while `vld_o && !ds_rdy`.
REQ-039 `en` deasserted mid-frame SHALL take effect only at the ACTIVE to IDLE transition.
REQ-040 `ovf_o` and `err_o` SHALL clear only on `rst`.

Reset
REQ-041 On `rst` high, the block SHALL go to IDLE with all counters 0 and the buffer empty.
REQ-042 On `rst` high, `vld_o` SHALL be 0, `dout` SHALL be 36'h0, `ovf_o` SHALL be 0, `err_o` SHALL be 0, and the synchronizer flops SHALL be 0.
REQ-043 Reset asserted mid-frame SHALL discard all partial and buffered data.
REQ-044 After reset, the block SHALL wait for `en` and then a fresh `vsync_i` falling edge before capturing.

Verification
REQ-045 Scenario: `en`=1, `vsync_i` falls, then bytes 10,80,20,90 are driven with `ds_rdy`=1 -> `dout` = 36'h1_9020_8010, `vld_o` high one clock after the 4th byte.
REQ-046 Scenario: a full frame with LINE_WORDS=4 and FRM_LINES=2 -> 8 words out; sb per word = 1,0,0,4,0,0,0,6; state returns to IDLE.
REQ-047 Scenario: `ds_rdy`=0 for 6 words with FIFO_DEPTH=4 -> first 4 words retained in order, words 5-6 dropped, `ovf_o`=1.
REQ-048 Scenario: `href_i` falls after 2 bytes of a word -> `err_o`=1, no word emitted, next line's first byte lands in lane 0.
REQ-049 Scenario: `vsync_i` rises mid-frame at line 1 -> `err_o`=1, block in WAIT_SOF, the next frame's first word has sb[0]=1.
REQ-050 Scenario: `rst` pulsed with 3 words buffered -> `vld_o`=0 and `dout`=0 immediately (asynchronous), and no words emitted until the next start of frame.
